// File: rtl/token_dropper.sv
// Drop-a-token board controller: accepts one column request at a time,
// animates the token falling one row per step_tick, then commits it to the
// lowest free cell of that column.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | ready for a request; only state with req_ready = 1
//   S_REJECT | one-cycle reject pulse for a bad or full column
//   S_FALL   | token animating; falling_row steps down on step_tick
//   S_PLACE  | one-cycle column pulse; board is written at its end
module token_dropper #(
    parameter int ROWS = 6,
    parameter int COLS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic [3:0]                 col_req,
    input  logic                       player,
    input  logic                       step_tick,
    output logic                       req_ready,
    output logic [COLS-1:0][2:0]       counters,
    output logic [COLS-1:0][ROWS-1:0]  occupied,
    output logic [COLS-1:0][ROWS-1:0]  owner,
    output logic                       falling_active,
    output logic [3:0]                 falling_col,
    output logic [2:0]                 falling_row,
    output logic [3:0]                 column,
    output logic                       reject
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REJECT,
        S_FALL,
        S_PLACE
    } state_t;

    localparam logic [2:0] ROWS_FULL = 3'(ROWS);
    localparam logic [2:0] ROW_TOP   = 3'(ROWS - 1);

    state_t                      state_q;
    logic [COLS-1:0][2:0]        counters_q;
    logic [COLS-1:0][ROWS-1:0]   occupied_q;
    logic [COLS-1:0][ROWS-1:0]   owner_q;
    logic [3:0]                  lat_col_q;
    logic                        lat_player_q;
    logic [2:0]                  target_q;
    logic [2:0]                  fall_row_q;
    logic                        falling_active_q;
    logic [3:0]                  column_q;
    logic                        reject_q;

    logic                        sel_valid;
    logic [2:0]                  sel_count;
    logic                        req_ok;

    // Decode the requested column: in range, and how many tokens it holds.
    always_comb begin
        sel_valid = 1'b0;
        sel_count = 3'd0;
        for (int c = 0; c < COLS; c++) begin
            if (col_req == 4'(c + 1)) begin
                sel_valid = 1'b1;
                sel_count = counters_q[c];
            end
        end
        // A full column is never accepted, so counters cannot pass ROWS.
        req_ok = sel_valid && (sel_count < ROWS_FULL);
    end

    // Sequencer and board storage; reset wins over everything, dropping any token in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            counters_q       <= '0;
            occupied_q       <= '0;
            owner_q          <= '0;
            lat_col_q        <= 4'd0;
            lat_player_q     <= 1'b0;
            target_q         <= 3'd0;
            fall_row_q       <= 3'd0;
            falling_active_q <= 1'b0;
            column_q         <= 4'd0;
            reject_q         <= 1'b0;
        end else begin
            column_q <= 4'd0;
            reject_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_ok) begin
                            lat_col_q        <= col_req;
                            lat_player_q     <= player;
                            target_q         <= sel_count;
                            fall_row_q       <= ROW_TOP;
                            falling_active_q <= 1'b1;
                            state_q          <= S_FALL;
                        end else begin
                            reject_q <= 1'b1;
                            state_q  <= S_REJECT;
                        end
                    end
                end
                S_REJECT: begin
                    state_q <= S_IDLE;
                end
                S_FALL: begin
                    if (step_tick) begin
                        if (fall_row_q == target_q) begin
                            column_q <= lat_col_q;
                            state_q  <= S_PLACE;
                        end else begin
                            fall_row_q <= fall_row_q - 3'd1;
                        end
                    end
                end
                S_PLACE: begin
                    // Counters still show the old value during this cycle.
                    for (int c = 0; c < COLS; c++) begin
                        if (lat_col_q == 4'(c + 1)) begin
                            counters_q[c] <= counters_q[c] + 3'd1;
                            for (int r = 0; r < ROWS; r++) begin
                                if (target_q == 3'(r)) begin
                                    occupied_q[c][r] <= 1'b1;
                                    owner_q[c][r]    <= lat_player_q;
                                end
                            end
                        end
                    end
                    lat_col_q        <= 4'd0;
                    fall_row_q       <= 3'd0;
                    falling_active_q <= 1'b0;
                    state_q          <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign counters       = counters_q;
    assign occupied       = occupied_q;
    assign owner          = owner_q;
    assign falling_active = falling_active_q;
    assign falling_col    = lat_col_q;
    assign falling_row    = fall_row_q;
    assign column         = column_q;
    assign reject         = reject_q;

endmodule

// File: tb/tb_token_dropper.sv
// Bench for token_dropper: directed scenarios with literal expectations plus
// a randomized run, all compared every cycle against a behavioural board model.
module tb_token_dropper;

    localparam int ROWS = 6;
    localparam int COLS = 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       req_valid;
    logic [3:0]                 col_req;
    logic                       player;
    logic                       step_tick;
    logic                       req_ready;
    logic [COLS-1:0][2:0]       counters;
    logic [COLS-1:0][ROWS-1:0]  occupied;
    logic [COLS-1:0][ROWS-1:0]  owner;
    logic                       falling_active;
    logic [3:0]                 falling_col;
    logic [2:0]                 falling_row;
    logic [3:0]                 column;
    logic                       reject;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    token_dropper #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .col_req        (col_req),
        .player         (player),
        .step_tick      (step_tick),
        .req_ready      (req_ready),
        .counters       (counters),
        .occupied       (occupied),
        .owner          (owner),
        .falling_active (falling_active),
        .falling_col    (falling_col),
        .falling_row    (falling_row),
        .column         (column),
        .reject         (reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: board as plain arrays, the token in flight as a few flags.
    int m_cnt [COLS];
    bit m_occ [COLS][ROWS];
    bit m_own [COLS][ROWS];
    bit m_busy_fall, m_placing, m_rejecting;
    int m_col, m_row, m_tgt;
    bit m_pl;

    // Model advances on each rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        if (reset) begin
            foreach (m_cnt[c]) m_cnt[c] = 0;
            foreach (m_occ[c, r]) begin m_occ[c][r] = 0; m_own[c][r] = 0; end
            m_busy_fall = 0; m_placing = 0; m_rejecting = 0;
            m_col = 0; m_row = 0; m_tgt = 0; m_pl = 0;
        end else if (m_placing) begin
            m_occ[m_col-1][m_tgt] = 1;
            m_own[m_col-1][m_tgt] = m_pl;
            m_cnt[m_col-1]++;
            m_placing = 0; m_col = 0; m_row = 0;
        end else if (m_rejecting) begin
            m_rejecting = 0;
        end else if (m_busy_fall) begin
            if (step_tick) begin
                if (m_row == m_tgt) begin m_busy_fall = 0; m_placing = 1; end
                else m_row--;
            end
        end else if (req_valid) begin
            if (col_req >= 1 && col_req <= COLS && m_cnt[col_req-1] < ROWS) begin
                m_busy_fall = 1; m_col = col_req; m_pl = player;
                m_tgt = m_cnt[col_req-1]; m_row = ROWS - 1;
            end else begin
                m_rejecting = 1;
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit act;
            act = m_busy_fall | m_placing;
            check("req_ready", int'(req_ready), int'(!(act | m_rejecting)));
            check("falling_active", int'(falling_active), int'(act));
            check("falling_col", int'(falling_col), act ? m_col : 0);
            check("falling_row", int'(falling_row), act ? m_row : 0);
            check("column", int'(column), m_placing ? m_col : 0);
            check("reject", int'(reject), int'(m_rejecting));
            for (int c = 0; c < COLS; c++) begin
                check($sformatf("counters[%0d]", c), int'(counters[c]), m_cnt[c]);
                for (int r = 0; r < ROWS; r++) begin
                    check($sformatf("occupied[%0d][%0d]", c, r), int'(occupied[c][r]), int'(m_occ[c][r]));
                    check($sformatf("owner[%0d][%0d]", c, r), int'(owner[c][r]), int'(m_own[c][r]));
                end
            end
        end
    end

    // Called at a falling edge with the block idle; returns at a falling edge idle again.
    task automatic drop(input int col, input bit pl);
        bit found;
        req_valid = 1; col_req = 4'(col); player = pl;
        @(negedge clk);
        req_valid = 0; step_tick = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (column != 0) found = 1;
        end
        step_tick = 0;
        check("drop_done", int'(found), 1);
        @(negedge clk);
    endtask

    task automatic expect_reject(input int col, input string name);
        req_valid = 1; col_req = 4'(col); player = 0;
        @(negedge clk);
        req_valid = 0;
        check({name, "_reject"}, int'(reject), 1);
        check({name, "_column"}, int'(column), 0);
        check({name, "_ready"}, int'(req_ready), 0);
        @(negedge clk);
        check({name, "_reject_end"}, int'(reject), 0);
        check({name, "_ready_end"}, int'(req_ready), 1);
    endtask

    initial begin
        bit found;
        reset = 1; req_valid = 0; col_req = 0; player = 0; step_tick = 0;
        @(negedge clk); @(negedge clk);
        reset = 0;
        chk_en = 1;
        check("rst_ready", int'(req_ready), 1);
        check("rst_counters", int'(counters), 0);
        check("rst_occupied", int'(occupied), 0);

        // Single drop into column 3, falling all the way to row 0.
        col_req = 3; player = 0; req_valid = 1;
        @(negedge clk);
        req_valid = 0; step_tick = 1;
        check("d1_row5", int'(falling_row), 5);
        check("d1_col", int'(falling_col), 3);
        for (int r = 4; r >= 0; r--) begin
            @(negedge clk);
            check($sformatf("d1_row%0d", r), int'(falling_row), r);
        end
        @(negedge clk);
        step_tick = 0;
        check("d1_place_column", int'(column), 3);
        check("d1_place_cnt", int'(counters[2]), 0);
        @(negedge clk);
        check("d1_cnt", int'(counters[2]), 1);
        check("d1_occ", int'(occupied[2][0]), 1);
        check("d1_own", int'(owner[2][0]), 0);
        check("d1_column_end", int'(column), 0);

        // Fill column 1 alternating players, then a full-column request.
        for (int i = 0; i < 6; i++) drop(1, (i % 2 == 0));
        check("full_cnt", int'(counters[0]), 6);
        check("full_own", int'(owner[0]), 6'b010101);
        expect_reject(1, "full");
        check("full_cnt_after", int'(counters[0]), 6);

        // Out-of-range columns.
        expect_reject(0, "col0");
        expect_reject(9, "col9");

        // Stall mid-fall and change the request inputs underneath the token.
        req_valid = 1; col_req = 4; player = 1;
        @(negedge clk);
        req_valid = 0; step_tick = 1;
        @(negedge clk); @(negedge clk);
        step_tick = 0; player = 0; col_req = 7;
        check("hold_row_start", int'(falling_row), 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            player = ~player; col_req = 4'($urandom_range(0, 15));
            check("hold_row", int'(falling_row), 3);
        end
        step_tick = 1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (column != 0) found = 1;
        end
        check("hold_place_seen", int'(found), 1);
        check("hold_place_col", int'(column), 4);
        step_tick = 0;
        @(negedge clk);
        check("hold_own", int'(owner[3][0]), 1);
        check("hold_occ7", int'(occupied[6]), 0);

        // Reset while falling_row = 2 discards the token and the board.
        req_valid = 1; col_req = 2; player = 1;
        @(negedge clk);
        req_valid = 0; step_tick = 1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (falling_row == 2) found = 1;
            else @(negedge clk);
        end
        check("rst_mid_row2", int'(found), 1);
        reset = 1;
        @(negedge clk);
        reset = 0; step_tick = 0;
        check("rst_mid_ready", int'(req_ready), 1);
        check("rst_mid_active", int'(falling_active), 0);
        check("rst_mid_row", int'(falling_row), 0);
        check("rst_mid_counters", int'(counters), 0);
        check("rst_mid_occupied", int'(occupied), 0);
        check("rst_mid_owner", int'(owner), 0);

        // Column 5 with five tokens: sixth lands on the first tick, seventh rejects.
        for (int i = 0; i < 5; i++) drop(5, 1'(i));
        req_valid = 1; col_req = 5; player = 1;
        @(negedge clk);
        req_valid = 0; step_tick = 1;
        check("top_row5", int'(falling_row), 5);
        @(negedge clk);
        step_tick = 0;
        check("top_place", int'(column), 5);
        @(negedge clk);
        check("top_cnt", int'(counters[4]), 6);
        check("top_own", int'(owner[4][5]), 1);
        expect_reject(5, "top_full");

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            req_valid = $urandom_range(0, 1);
            col_req   = 4'($urandom_range(0, 10));
            player    = $urandom_range(0, 1);
            step_tick = ($urandom_range(0, 9) < 6);
            @(negedge clk);
        end
        reset = 0; req_valid = 0; step_tick = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/token_dropper.md
TOKEN_DROPPER -- requirements
Module: token_dropper

Interface
REQ-001 Parameter ROWS, default 6, rows per column; legal range 1..7; row 0 is the bottom row.
REQ-002 Parameter COLS, default 8, number of columns; legal range 1..15.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  a drop request is present.
REQ-006 col_req  in  4  requested column, 1..COLS; 0 or a value above COLS is invalid.
REQ-007 player  in  1  owner of the token: 0 = player 1, 1 = player 2.
REQ-008 step_tick  in  1  animation step enable; one fall step per asserted cycle.
REQ-009 req_ready  out  1  the block can accept a request this cycle.
REQ-010 counters  out  [COLS-1:0][2:0]  tokens currently stacked in each column.
REQ-011 occupied  out  [COLS-1:0][ROWS-1:0]  cell holds a token.
REQ-012 owner  out  [COLS-1:0][ROWS-1:0]  player of each cell; SHALL be 0 wherever occupied is 0.
REQ-013 falling_active  out  1  a token is animating.
REQ-014 falling_col  out  4  column of the animating token, 1-based; 0 when not falling.
REQ-015 falling_row  out  3  current row of the animating token; 0 when not falling.
REQ-016 column  out  4  one-cycle pulse of the committed column, 1-based; 0 otherwise.
REQ-017 reject  out  1  one-cycle pulse for an invalid or full-column request.

Function
REQ-018 States SHALL be IDLE, REJECT, FALL and PLACE; req_ready SHALL be 1 only in IDLE.
REQ-019 IDLE + req_valid with invalid col_req or counters[col_req-1]==ROWS SHALL go to REJECT, leaving board and counters unchanged.
REQ-020 REJECT SHALL last one cycle, with reject=1 and column=0, then return to IDLE.
REQ-021 IDLE + req_valid with a valid, non-full column SHALL latch the column, player and target row = counters[c], set falling_row=ROWS-1, and go to FALL.
REQ-022 In FALL with step_tick=1: if falling_row == target, go to PLACE; otherwise decrement falling_row by 1.
REQ-023 In FALL with step_tick=0, all state SHALL hold.
REQ-024 A target of ROWS-1 SHALL reach PLACE on the first step_tick.
REQ-025 PLACE SHALL last exactly one cycle, with column = latched column (1-based).
REQ-026 At the clock edge ending PLACE, the block SHALL set occupied[c][target]=1 and owner[c][target]=latched player, increment counters[c] by 1, and return to IDLE.
REQ-027 During the PLACE cycle, counters SHALL still show the pre-increment value, so a downstream turn tracker sees a non-full column alongside the column pulse.
REQ-028 counters SHALL never exceed ROWS; an increment past ROWS SHALL be impossible by construction.
REQ-029 req_valid asserted outside IDLE SHALL be ignored and not queued; the requester must hold or re-present it.
REQ-030 player and col_req SHALL be sampled only at acceptance; later changes SHALL not affect the token in flight.
REQ-031 step_tick in IDLE, REJECT or PLACE SHALL have no effect.
REQ-032 falling_active SHALL be 1 exactly in FALL and PLACE; falling_col and falling_row SHALL be valid in those states.
REQ-033 Back-to-back requests: the earliest accept after PLACE is the cycle after return to IDLE, using the updated counters.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL go to IDLE and clear counters, occupied and owner to 0.
REQ-035 Reset SHALL also drive column, reject, falling_active, falling_col and falling_row to 0 and req_ready to 1.
REQ-036 Reset SHALL take priority over every other input in any state, including mid-FALL, and the in-flight token SHALL be discarded.

Verification
REQ-037 After reset, col_req=3, player=0, one cycle of req_valid, then step_tick held 1 -> falling_row 5,4,3,2,1,0, then column=3 for one cycle with counters[2]=0, then counters[2]=1, occupied[2][0]=1, owner[2][0]=0.
REQ-038 Fill column 1 with six drops alternating player 1/0, then request column 1 -> reject=1 for one cycle, counters[0] stays 6, column stays 0.
REQ-039 col_req=0 and col_req=9 with req_valid -> reject pulse each time, no state change.
REQ-040 step_tick low for 10 cycles mid-FALL -> falling_row frozen; change player and col_req during this time -> placed token keeps the latched values.
REQ-041 Assert reset while falling_row=2 -> next cycle all outputs at reset values, req_ready=1, board empty.
REQ-042 Column 5 holding 5 tokens, request column 5 -> falling_row=5 places on the first tick; the next request to column 5 rejects.
